// File: rtl/jtag_dmi_arbiter.sv
// Two-port DMI arbiter in the TCK domain: round-robin grant of one transaction at a time,
// local answers for non-read/write ops, and timeout conversion of a hung DM into a failed response.
module jtag_dmi_arbiter #(
    parameter int DMI_ADDR_BITS  = 6,
    parameter int DMI_DATA_BITS  = 32,
    parameter int DMI_OP_BITS    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int REQ_BITS      = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
    input  logic                jtag_tck_i,
    input  logic                jtag_trst_ni,
    input  logic [REQ_BITS-1:0] req0_data_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [REQ_BITS-1:0] req1_data_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    output logic [REQ_BITS-1:0] resp0_data_o,
    output logic                resp0_valid_o,
    input  logic                resp0_ready_i,
    output logic [REQ_BITS-1:0] resp1_data_o,
    output logic                resp1_valid_o,
    input  logic                resp1_ready_i,
    output logic [REQ_BITS-1:0] dmi_req_data_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    input  logic [REQ_BITS-1:0] dmi_resp_data_i,
    input  logic                dmi_resp_valid_i,
    output logic                dmi_resp_ready_o,
    output logic                owner_o,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [DMI_OP_BITS-1:0] OP_READ  = DMI_OP_BITS'(1);
    localparam logic [DMI_OP_BITS-1:0] OP_WRITE = DMI_OP_BITS'(2);
    localparam logic [DMI_OP_BITS-1:0] OP_OK    = DMI_OP_BITS'(0);
    localparam logic [DMI_OP_BITS-1:0] OP_FAIL  = DMI_OP_BITS'(2);

    logic [1:0]          r_state;
    logic [REQ_BITS-1:0] r_req;
    logic [REQ_BITS-1:0] r_resp;
    logic                r_owner;
    logic                r_last;
    logic                r_stale;
    logic [CNT_W-1:0]    r_cnt;

    logic                   w_accept;
    logic                   w_winner;
    logic [REQ_BITS-1:0]    w_req_word;
    logic [DMI_OP_BITS-1:0] w_req_op;
    logic                   w_resp_ready;
    logic                   w_timeout;

    // A tie goes to the port that was not granted last; r_last resets to 1 so port 0 wins first.
    assign w_winner     = (req0_valid_i && req1_valid_i) ? ~r_last : req1_valid_i;
    assign w_accept     = (r_state == S_IDLE) && !r_stale && (req0_valid_i || req1_valid_i);
    assign w_req_word   = w_winner ? req1_data_i : req0_data_i;
    assign w_req_op     = w_req_word[DMI_OP_BITS-1:0];
    assign w_resp_ready = r_owner ? resp1_ready_i : resp0_ready_i;
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_resp  <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_stale <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // The first DM response after a timeout belongs to the abandoned request.
            if (r_stale && dmi_resp_valid_i && (r_state != S_WAIT)) begin
                r_stale <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req   <= w_req_word;
                        r_owner <= w_winner;
                        r_last  <= w_winner;
                        if ((w_req_op == OP_READ) || (w_req_op == OP_WRITE)) begin
                            r_state <= S_REQ;
                        end else begin
                            r_resp  <= {w_req_word[REQ_BITS-1:DMI_OP_BITS], OP_OK};
                            r_state <= S_DELIVER;
                        end
                    end
                end
                S_REQ: begin
                    if (dmi_req_ready_i) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmi_resp_valid_i) begin
                        r_resp  <= dmi_resp_data_i;
                        r_state <= S_DELIVER;
                    end else if (w_timeout) begin
                        r_resp  <= {r_req[REQ_BITS-1:DMI_OP_BITS], OP_FAIL};
                        r_stale <= 1'b1;
                        r_state <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    if (w_resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_resp  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready_o     = w_accept && !w_winner;
    assign req1_ready_o     = w_accept && w_winner;
    assign dmi_req_valid_o  = (r_state == S_REQ);
    assign dmi_req_data_o   = r_req;
    assign dmi_resp_ready_o = (r_state == S_WAIT) || r_stale;
    assign resp0_valid_o    = (r_state == S_DELIVER) && !r_owner;
    assign resp1_valid_o    = (r_state == S_DELIVER) && r_owner;
    assign resp0_data_o     = r_resp;
    assign resp1_data_o     = r_resp;
    assign owner_o          = r_owner;
    assign busy_o           = (r_state != S_IDLE) || r_stale;

endmodule

// File: tb/tb_jtag_dmi_arbiter.sv
// Scoreboard bench for jtag_dmi_arbiter: directed stimulus pushes expected words,
// a negedge monitor pops and compares on every DM request and response handshake.
module tb_jtag_dmi_arbiter;

    localparam int RB = 40;

    typedef struct packed {
        logic [RB-1:0] w;
        logic          o;
    } dmi_exp_t;

    logic          clk = 1'b0;
    logic          trst_n = 1'b0;
    logic [RB-1:0] req0_data = '0, req1_data = '0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [RB-1:0] resp0_data, resp1_data;
    logic          resp0_valid, resp1_valid;
    logic          resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [RB-1:0] dmi_req_data;
    logic          dmi_req_valid;
    logic          dmi_req_ready = 1'b0;
    logic [RB-1:0] dmi_resp_data = '0;
    logic          dmi_resp_valid = 1'b0;
    logic          dmi_resp_ready;
    logic          owner, busy;

    int checks = 0;
    int errors = 0;
    int dmi_vld_cyc = 0;

    dmi_exp_t      exp_dmi[$];
    logic [RB-1:0] exp_r0[$];
    logic [RB-1:0] exp_r1[$];

    logic          p_r0v = 1'b0, p_r0r = 1'b0, p_r1v = 1'b0, p_r1r = 1'b0, p_dv = 1'b0, p_dr = 1'b0;
    logic [RB-1:0] p_r0d = '0, p_r1d = '0, p_dd = '0;

    jtag_dmi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .jtag_tck_i       (clk),
        .jtag_trst_ni     (trst_n),
        .req0_data_i      (req0_data),
        .req0_valid_i     (req0_valid),
        .req0_ready_o     (req0_ready),
        .req1_data_i      (req1_data),
        .req1_valid_i     (req1_valid),
        .req1_ready_o     (req1_ready),
        .resp0_data_o     (resp0_data),
        .resp0_valid_o    (resp0_valid),
        .resp0_ready_i    (resp0_ready),
        .resp1_data_o     (resp1_data),
        .resp1_valid_o    (resp1_valid),
        .resp1_ready_i    (resp1_ready),
        .dmi_req_data_o   (dmi_req_data),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_resp_data_i  (dmi_resp_data),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .owner_o          (owner),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [RB-1:0] mk(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: handshakes, hold stability, and no valid dropped before ready.
    always @(negedge clk) begin
        if (trst_n) begin
            if (p_r0v && !p_r0r) begin
                checks++;
                if (!(resp0_valid && resp0_data === p_r0d)) begin
                    errors++;
                    $display("FAIL resp0_hold actual=%b/%h expected=1/%h", resp0_valid, resp0_data, p_r0d);
                end
            end
            if (p_r1v && !p_r1r) begin
                checks++;
                if (!(resp1_valid && resp1_data === p_r1d)) begin
                    errors++;
                    $display("FAIL resp1_hold actual=%b/%h expected=1/%h", resp1_valid, resp1_data, p_r1d);
                end
            end
            if (p_dv && !p_dr) begin
                checks++;
                if (!(dmi_req_valid && dmi_req_data === p_dd)) begin
                    errors++;
                    $display("FAIL dmi_req_hold actual=%b/%h expected=1/%h", dmi_req_valid, dmi_req_data, p_dd);
                end
            end
            if (resp0_valid && resp0_ready) begin
                checks++;
                if (exp_r0.size() == 0) begin
                    errors++;
                    $display("FAIL resp0_unexpected actual=%h expected=none", resp0_data);
                end else begin
                    logic [RB-1:0] e;
                    e = exp_r0.pop_front();
                    if (resp0_data !== e) begin
                        errors++;
                        $display("FAIL resp0_data actual=%h expected=%h", resp0_data, e);
                    end
                end
            end
            if (resp1_valid && resp1_ready) begin
                checks++;
                if (exp_r1.size() == 0) begin
                    errors++;
                    $display("FAIL resp1_unexpected actual=%h expected=none", resp1_data);
                end else begin
                    logic [RB-1:0] e;
                    e = exp_r1.pop_front();
                    if (resp1_data !== e) begin
                        errors++;
                        $display("FAIL resp1_data actual=%h expected=%h", resp1_data, e);
                    end
                end
            end
            if (dmi_req_valid && dmi_req_ready) begin
                checks++;
                if (exp_dmi.size() == 0) begin
                    errors++;
                    $display("FAIL dmi_req_unexpected actual=%h expected=none", dmi_req_data);
                end else begin
                    dmi_exp_t e;
                    e = exp_dmi.pop_front();
                    if (dmi_req_data !== e.w || owner !== e.o) begin
                        errors++;
                        $display("FAIL dmi_req actual=%h/owner%b expected=%h/owner%b", dmi_req_data, owner, e.w, e.o);
                    end
                end
            end
        end
        if (dmi_req_valid) dmi_vld_cyc <= dmi_vld_cyc + 1;
        p_r0v <= resp0_valid; p_r0r <= resp0_ready; p_r0d <= resp0_data;
        p_r1v <= resp1_valid; p_r1r <= resp1_ready; p_r1d <= resp1_data;
        p_dv  <= dmi_req_valid; p_dr <= dmi_req_ready; p_dd <= dmi_req_data;
    end

    task automatic send(input int p, input logic [RB-1:0] w);
        bit got;
        got = 1'b0;
        if (p == 0) begin req0_data = w; req0_valid = 1'b1; end
        else begin req1_data = w; req1_valid = 1'b1; end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((p == 0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL req%0d_accept actual=no_ready expected=ready", p);
        end
    endtask

    task automatic dm_serve(input logic [RB-1:0] rw, input int rdly, input bit respond, input int resp_dly);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dmi_req_valid) begin got = 1'b1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL dm_wait actual=no_valid expected=dmi_req_valid");
            return;
        end
        repeat (rdly) begin @(posedge clk); #1; end
        dmi_req_ready = 1'b1;
        @(posedge clk); #1;
        dmi_req_ready = 1'b0;
        if (!respond) return;
        repeat (resp_dly) begin @(posedge clk); #1; end
        dmi_resp_data = rw;
        dmi_resp_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dmi_resp_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        dmi_resp_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL dm_resp_ready actual=0 expected=1");
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_r0.size() == 0 && exp_r1.size() == 0 && exp_dmi.size() == 0) begin done = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain actual=%0d/%0d/%0d expected=0/0/0", exp_r0.size(), exp_r1.size(), exp_dmi.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RB-1:0] rsp [4];
        int            n;
        int            snap;

        // Reset state
        #3;
        chk("rst_dmi_req_valid", dmi_req_valid, 0);
        chk("rst_dmi_resp_ready", dmi_resp_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp1_valid", resp1_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_dmi_req_data", dmi_req_data, 0);
        @(negedge clk); trst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous writes: grants 0,1,0,1
        rsp[0] = mk(6'h01, 32'h0, 2'b00); rsp[1] = mk(6'h02, 32'h0, 2'b00);
        rsp[2] = mk(6'h03, 32'h0, 2'b00); rsp[3] = mk(6'h04, 32'h0, 2'b00);
        exp_dmi.push_back('{mk(6'h01, 32'hA0, 2'b10), 1'b0});
        exp_dmi.push_back('{mk(6'h02, 32'hB0, 2'b10), 1'b1});
        exp_dmi.push_back('{mk(6'h03, 32'hA1, 2'b10), 1'b0});
        exp_dmi.push_back('{mk(6'h04, 32'hB1, 2'b10), 1'b1});
        exp_r0.push_back(rsp[0]); exp_r0.push_back(rsp[2]);
        exp_r1.push_back(rsp[1]); exp_r1.push_back(rsp[3]);
        fork
            begin send(0, mk(6'h01, 32'hA0, 2'b10)); send(0, mk(6'h03, 32'hA1, 2'b10)); end
            begin send(1, mk(6'h02, 32'hB0, 2'b10)); send(1, mk(6'h04, 32'hB1, 2'b10)); end
            begin for (int k = 0; k < 4; k++) dm_serve(rsp[k], 0, 1'b1, 1); end
        join
        wait_drain();

        // Single read from port 0
        exp_dmi.push_back('{mk(6'h10, 32'h0, 2'b01), 1'b0});
        exp_r0.push_back(mk(6'h10, 32'hDEADBEEF, 2'b00));
        fork
            begin send(0, mk(6'h10, 32'h0, 2'b01)); chk("read_req_latency", dmi_req_valid, 1); end
            dm_serve(mk(6'h10, 32'hDEADBEEF, 2'b00), 0, 1'b1, 1);
        join
        wait_drain();
        chk("read_busy_after", busy, 0);

        // Local op from port 1
        snap = dmi_vld_cyc;
        exp_r1.push_back(mk(6'h11, 32'h5, 2'b00));
        send(1, mk(6'h11, 32'h5, 2'b00));
        chk("local_resp_latency", resp1_valid, 1);
        chk("local_owner", owner, 1);
        wait_drain();
        chk("local_no_dmi", dmi_vld_cyc - snap, 0);

        // Backpressure on both sides
        exp_dmi.push_back('{mk(6'h20, 32'h0, 2'b01), 1'b0});
        exp_r0.push_back(mk(6'h20, 32'hCAFEF00D, 2'b00));
        resp0_ready = 1'b0;
        fork
            send(0, mk(6'h20, 32'h0, 2'b01));
            dm_serve(mk(6'h20, 32'hCAFEF00D, 2'b00), 5, 1'b1, 1);
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (resp0_valid) break;
                end
                repeat (3) begin @(posedge clk); #1; end
                resp0_ready = 1'b1;
            end
        join
        wait_drain();

        // Timeout, then stall until the late response is drained
        exp_dmi.push_back('{mk(6'h22, 32'h0, 2'b01), 1'b1});
        exp_r1.push_back(mk(6'h22, 32'h0, 2'b10));
        fork
            send(1, mk(6'h22, 32'h0, 2'b01));
            dm_serve('0, 0, 1'b0, 0);
        join
        n = 0;
        while (!resp1_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("timeout_cycles", n, 8);
        wait_drain();
        chk("stale_busy", busy, 1);
        chk("stale_resp_ready", dmi_resp_ready, 1);
        exp_dmi.push_back('{mk(6'h23, 32'h1234, 2'b10), 1'b0});
        exp_r0.push_back(mk(6'h23, 32'h0, 2'b00));
        fork
            send(0, mk(6'h23, 32'h1234, 2'b10));
            begin
                repeat (5) begin @(posedge clk); #1; end
                chk("stale_no_grant", req0_ready, 0);
                chk("stale_no_dmi_req", dmi_req_valid, 0);
                dmi_resp_data = mk(6'h22, 32'hBAD, 2'b00);
                dmi_resp_valid = 1'b1;
                @(posedge clk); #1;
                dmi_resp_valid = 1'b0;
                dm_serve(mk(6'h23, 32'h0, 2'b00), 0, 1'b1, 1);
            end
        join
        wait_drain();
        chk("stale_cleared_busy", busy, 0);

        // Async reset in WAIT_RESP, then tie goes to port 0
        exp_dmi.push_back('{mk(6'h30, 32'h0, 2'b01), 1'b0});
        fork
            send(0, mk(6'h30, 32'h0, 2'b01));
            dm_serve('0, 0, 1'b0, 0);
        join
        chk("wait_resp_ready", dmi_resp_ready, 1);
        @(posedge clk); #2;
        trst_n = 1'b0;
        #1;
        chk("arst_resp_ready", dmi_resp_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dmi_req_valid", dmi_req_valid, 0);
        chk("arst_resp0_valid", resp0_valid, 0);
        chk("arst_resp1_valid", resp1_valid, 0);
        chk("arst_owner", owner, 0);
        chk("arst_req_data", dmi_req_data, 0);
        chk("arst_resp_data", resp0_data, 0);
        @(posedge clk);
        @(negedge clk); trst_n = 1'b1;
        @(posedge clk); #1;
        exp_dmi.push_back('{mk(6'h31, 32'h7, 2'b10), 1'b0});
        exp_dmi.push_back('{mk(6'h32, 32'h8, 2'b10), 1'b1});
        exp_r0.push_back(mk(6'h31, 32'h70, 2'b00));
        exp_r1.push_back(mk(6'h32, 32'h80, 2'b00));
        fork
            send(0, mk(6'h31, 32'h7, 2'b10));
            send(1, mk(6'h32, 32'h8, 2'b10));
            begin
                dm_serve(mk(6'h31, 32'h70, 2'b00), 0, 1'b1, 1);
                dm_serve(mk(6'h32, 32'h80, 2'b00), 0, 1'b1, 1);
            end
        join
        wait_drain();
        chk("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
